// File: rtl/game_step_scheduler.sv
// Snake game step sequencer: IDLE -> WAIT_TICK -> MOVE -> CHECK -> DRAW, with score, speed level and overrun tracking.
// Latency: iTick to oMove is 1 cycle. Strobes are decoded from the state register only.
// Backpressure: DRAW holds until iDrawDone (or DRAW_TIMEOUT cycles when SCHED_TIMEOUT_EN is defined); late ticks are dropped and flagged.
module game_step_scheduler #(
    parameter int FOOD_PER_LEVEL = 4,
    parameter int DRAW_TIMEOUT   = 1023
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iTick,
    input  logic       iStart,
    input  logic       iPause,
    input  logic       iCollision,
    input  logic       iFoodEaten,
    input  logic       iDrawDone,
    output logic [1:0] oSpeed,
    output logic       oMove,
    output logic       oCheck,
    output logic       oDraw,
    output logic [7:0] oScore,
    output logic       oRunning,
    output logic       oGameOver,
    output logic       oOverrun,
    output logic       oFault
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_MOVE      = 3'd2;
    localparam logic [2:0] S_CHECK     = 3'd3;
    localparam logic [2:0] S_DRAW      = 3'd4;
    localparam logic [2:0] S_OVER      = 3'd5;

    localparam logic [3:0] LEVEL_LAST = 4'(FOOD_PER_LEVEL - 1);

    generate
        if (FOOD_PER_LEVEL < 1 || FOOD_PER_LEVEL > 15 ||
            DRAW_TIMEOUT < 1 || DRAW_TIMEOUT > 1023) begin : g_param_check
            $error("game_step_scheduler: parameter out of range");
        end
    endgenerate

    logic [2:0] state_q,   state_d;
    logic [7:0] score_q,   score_d;
    logic [1:0] speed_q,   speed_d;
    logic [3:0] level_q,   level_d;
    logic       overrun_q, overrun_d;

`ifdef SCHED_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(DRAW_TIMEOUT - 1);
    logic [9:0] tmo_q,   tmo_d;
    logic       fault_q, fault_d;
`endif

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        speed_d   = speed_q;
        level_d   = level_q;
        overrun_d = overrun_q;
`ifdef SCHED_TIMEOUT_EN
        tmo_d     = '0;
        fault_d   = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d   = S_WAIT_TICK;
                    score_d   = '0;
                    speed_d   = '0;
                    level_d   = '0;
                    overrun_d = 1'b0;
`ifdef SCHED_TIMEOUT_EN
                    fault_d   = 1'b0;
`endif
                end
            end
            S_WAIT_TICK: begin
                if (iTick && !iPause) state_d = S_MOVE;
            end
            S_MOVE: begin
                if (iTick && !iPause) overrun_d = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (iTick && !iPause) overrun_d = 1'b1;
                if (iCollision) begin
                    state_d = S_OVER;
                end else begin
                    state_d = S_DRAW;
                    if (iFoodEaten) begin
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        // Speed only moves here so the divider sees one value per whole step.
                        if (level_q == LEVEL_LAST) begin
                            level_d = '0;
                            if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
                        end else begin
                            level_d = level_q + 4'd1;
                        end
                    end
                end
            end
            S_DRAW: begin
                if (iTick && !iPause) overrun_d = 1'b1;
`ifdef SCHED_TIMEOUT_EN
                if (iDrawDone) begin
                    state_d = S_WAIT_TICK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_WAIT_TICK;
                    fault_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 10'd1;
                end
`else
                if (iDrawDone) state_d = S_WAIT_TICK;
`endif
            end
            S_OVER: begin
                if (iStart) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q   <= S_IDLE;
            score_q   <= '0;
            speed_q   <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            speed_q   <= speed_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            tmo_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
        end
    end
    assign oFault = fault_q;
`else
    assign oFault = 1'b0;
`endif

    assign oMove     = (state_q == S_MOVE);
    assign oCheck    = (state_q == S_CHECK);
    assign oDraw     = (state_q == S_DRAW);
    assign oGameOver = (state_q == S_OVER);
    assign oRunning  = (state_q == S_WAIT_TICK) || (state_q == S_MOVE) ||
                       (state_q == S_CHECK) || (state_q == S_DRAW);
    assign oScore    = score_q;
    assign oSpeed    = speed_q;
    assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_game_step_scheduler.sv
// Directed bench for game_step_scheduler (FOOD_PER_LEVEL=4, DRAW_TIMEOUT=8).
module tb_game_step_scheduler;

    logic       iClock = 1'b0;
    logic       iReset, iTick, iStart, iPause, iCollision, iFoodEaten, iDrawDone;
    logic [1:0] oSpeed;
    logic       oMove, oCheck, oDraw, oRunning, oGameOver, oOverrun, oFault;
    logic [7:0] oScore;

    int vec  = 0;
    int errs = 0;
    logic [7:0] exp_score = 8'd0;

    game_step_scheduler #(.FOOD_PER_LEVEL(4), .DRAW_TIMEOUT(8)) dut (
        .iClock(iClock), .iReset(iReset), .iTick(iTick), .iStart(iStart),
        .iPause(iPause), .iCollision(iCollision), .iFoodEaten(iFoodEaten),
        .iDrawDone(iDrawDone), .oSpeed(oSpeed), .oMove(oMove), .oCheck(oCheck),
        .oDraw(oDraw), .oScore(oScore), .oRunning(oRunning), .oGameOver(oGameOver),
        .oOverrun(oOverrun), .oFault(oFault)
    );

    always #5 iClock = ~iClock;

    function automatic logic [16:0] outs();
        return {oSpeed, oMove, oCheck, oDraw, oScore, oRunning, oGameOver, oOverrun, oFault};
    endfunction

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    // One full step with no mid-step checks; ends in WAIT_TICK (or OVER on collision).
    task automatic do_step(input logic food, input logic coll);
        iTick = 1'b1; step(); iTick = 1'b0;
        step();
        iFoodEaten = food; iCollision = coll;
        step();
        iFoodEaten = 1'b0; iCollision = 1'b0;
        if (!coll) begin
            iDrawDone = 1'b1; step(); iDrawDone = 1'b0;
        end
        if (food && !coll && exp_score != 8'hFF) exp_score = exp_score + 8'd1;
    endtask

    task automatic test_reset();
        iReset = 1'b0;
        step(); step();
        vec++;
        if (outs() !== 17'd0) begin
            errs++; $display("FAIL reset_outs: got %h expected %h", outs(), 17'd0);
        end
        iReset = 1'b1;
        step();
        vec++;
        if (outs() !== 17'd0) begin
            errs++; $display("FAIL idle_hold: got %h expected %h", outs(), 17'd0);
        end
    endtask

    task automatic test_start();
        iStart = 1'b1; step(); iStart = 1'b0;
        vec++;
        if ({oRunning, oScore, oSpeed, oMove, oGameOver} !== {1'b1, 8'd0, 2'd0, 1'b0, 1'b0}) begin
            errs++; $display("FAIL start: got run=%b score=%0d speed=%0d move=%b over=%b expected 1 0 0 0 0",
                             oRunning, oScore, oSpeed, oMove, oGameOver);
        end
        exp_score = 8'd0;
    endtask

    task automatic test_step_timing();
        logic [2:0] exp_str [1:7];
        exp_str[1] = 3'b100; exp_str[2] = 3'b010; exp_str[3] = 3'b001;
        exp_str[4] = 3'b001; exp_str[5] = 3'b001; exp_str[6] = 3'b001; exp_str[7] = 3'b000;
        iTick = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            step();
            iTick = 1'b0;
            vec++;
            if ({oMove, oCheck, oDraw} !== exp_str[c]) begin
                errs++; $display("FAIL timing_cycle%0d: got mcd=%b expected %b", c, {oMove, oCheck, oDraw}, exp_str[c]);
            end
            iDrawDone = (c == 6);
        end
        iDrawDone = 1'b0;
        vec++;
        if ({oRunning, oOverrun, oScore} !== {1'b1, 1'b0, 8'd0}) begin
            errs++; $display("FAIL timing_end: got run=%b ovr=%b score=%0d expected 1 0 0", oRunning, oOverrun, oScore);
        end
    endtask

    task automatic test_food_levels();
        for (int i = 0; i < 3; i++) do_step(1'b1, 1'b0);
        vec++;
        if ({oScore, oSpeed} !== {8'd3, 2'd0}) begin
            errs++; $display("FAIL food3: got score=%0d speed=%0d expected 3 0", oScore, oSpeed);
        end
        iTick = 1'b1; step(); iTick = 1'b0;
        step();
        iFoodEaten = 1'b1;
        vec++;
        if (oSpeed !== 2'd0) begin
            errs++; $display("FAIL speed_in_check: got %0d expected 0", oSpeed);
        end
        step();
        iFoodEaten = 1'b0;
        exp_score = 8'd4;
        vec++;
        if ({oDraw, oScore, oSpeed} !== {1'b1, 8'd4, 2'd1}) begin
            errs++; $display("FAIL food4: got draw=%b score=%0d speed=%0d expected 1 4 1", oDraw, oScore, oSpeed);
        end
        iDrawDone = 1'b1; step(); iDrawDone = 1'b0;
        do_step(1'b0, 1'b0);
        vec++;
        if ({oScore, oSpeed} !== {8'd4, 2'd1}) begin
            errs++; $display("FAIL nofood: got score=%0d speed=%0d expected 4 1", oScore, oSpeed);
        end
        for (int i = 0; i < 12; i++) do_step(1'b1, 1'b0);
        vec++;
        if ({oScore, oSpeed} !== {8'd16, 2'd3}) begin
            errs++; $display("FAIL food16: got score=%0d speed=%0d expected 16 3", oScore, oSpeed);
        end
        for (int i = 0; i < 4; i++) do_step(1'b1, 1'b0);
        vec++;
        if ({oScore, oSpeed} !== {8'd20, 2'd3}) begin
            errs++; $display("FAIL speed_sat: got score=%0d speed=%0d expected 20 3", oScore, oSpeed);
        end
    endtask

    task automatic test_pause();
        logic saw_move;
        saw_move = 1'b0;
        iPause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iTick = 1'b1; step(); iTick = 1'b0;
            saw_move = saw_move | oMove;
            step();
            saw_move = saw_move | oMove;
        end
        vec++;
        if ({saw_move, oOverrun, oRunning} !== 3'b001) begin
            errs++; $display("FAIL pause: got move=%b ovr=%b run=%b expected 0 0 1", saw_move, oOverrun, oRunning);
        end
        iPause = 1'b0;
        iTick = 1'b1; step(); iTick = 1'b0;
        iPause = 1'b1;
        step();
        vec++;
        if (oCheck !== 1'b1) begin
            errs++; $display("FAIL pause_inflight: got check=%b expected 1", oCheck);
        end
        step();
        iPause = 1'b0;
        iDrawDone = 1'b1; step(); iDrawDone = 1'b0;
    endtask

    task automatic test_overrun();
        iTick = 1'b1; step(); iTick = 1'b0;
        step(); step();
        iTick = 1'b1; step(); iTick = 1'b0;
        vec++;
        if ({oOverrun, oDraw} !== 2'b11) begin
            errs++; $display("FAIL overrun: got ovr=%b draw=%b expected 1 1", oOverrun, oDraw);
        end
        iDrawDone = 1'b1; step(); iDrawDone = 1'b0;
        vec++;
        if ({oDraw, oRunning, oMove, oOverrun} !== 4'b0101) begin
            errs++; $display("FAIL overrun_frame: got draw=%b run=%b move=%b ovr=%b expected 0 1 0 1",
                             oDraw, oRunning, oMove, oOverrun);
        end
    endtask

    task automatic test_timeout();
        int draw_cycles;
        iTick = 1'b1; step(); iTick = 1'b0;
        step(); step();
        draw_cycles = 0;
`ifdef SCHED_TIMEOUT_EN
        for (int i = 0; i < 12 && oDraw; i++) begin
            draw_cycles++;
            step();
        end
        vec++;
        if ({draw_cycles, oRunning, oFault} !== {32'd8, 1'b1, 1'b1}) begin
            errs++; $display("FAIL timeout: got draw_cycles=%0d run=%b fault=%b expected 8 1 1",
                             draw_cycles, oRunning, oFault);
        end
`else
        for (int i = 0; i < 20; i++) begin
            if (oDraw) draw_cycles++;
            step();
        end
        vec++;
        if ({draw_cycles, oDraw, oFault} !== {32'd20, 1'b1, 1'b0}) begin
            errs++; $display("FAIL no_timeout: got draw_cycles=%0d draw=%b fault=%b expected 20 1 0",
                             draw_cycles, oDraw, oFault);
        end
        iDrawDone = 1'b1; step(); iDrawDone = 1'b0;
`endif
    endtask

    task automatic test_collision();
        do_step(1'b1, 1'b1);
        vec++;
        if ({oGameOver, oRunning, oDraw, oScore} !== {1'b1, 1'b0, 1'b0, exp_score}) begin
            errs++; $display("FAIL collision: got over=%b run=%b draw=%b score=%0d expected 1 0 0 %0d",
                             oGameOver, oRunning, oDraw, oScore, exp_score);
        end
        step(); step();
        vec++;
        if (oGameOver !== 1'b1) begin
            errs++; $display("FAIL over_hold: got %b expected 1", oGameOver);
        end
        iStart = 1'b1; step(); iStart = 1'b0;
        vec++;
        if ({oGameOver, oRunning, oScore} !== {1'b0, 1'b0, exp_score}) begin
            errs++; $display("FAIL over_to_idle: got over=%b run=%b score=%0d expected 0 0 %0d",
                             oGameOver, oRunning, oScore, exp_score);
        end
        step();
        iStart = 1'b1; step(); iStart = 1'b0;
        exp_score = 8'd0;
        vec++;
        if ({oRunning, oScore, oSpeed, oOverrun, oFault} !== {1'b1, 8'd0, 2'd0, 1'b0, 1'b0}) begin
            errs++; $display("FAIL restart: got run=%b score=%0d speed=%0d ovr=%b fault=%b expected 1 0 0 0 0",
                             oRunning, oScore, oSpeed, oOverrun, oFault);
        end
    endtask

    task automatic test_reset_mid();
        do_step(1'b1, 1'b0);
        iTick = 1'b1; step(); iTick = 1'b0;
        iReset = 1'b0;
        step();
        vec++;
        if (outs() !== 17'd0) begin
            errs++; $display("FAIL reset_mid: got %h expected %h", outs(), 17'd0);
        end
        iReset = 1'b1;
        step();
        vec++;
        if ({oCheck, oRunning, oScore} !== {1'b0, 1'b0, 8'd0}) begin
            errs++; $display("FAIL reset_mid_after: got check=%b run=%b score=%0d expected 0 0 0",
                             oCheck, oRunning, oScore);
        end
    endtask

    initial begin
        iReset = 1'b0; iTick = 1'b0; iStart = 1'b0; iPause = 1'b0;
        iCollision = 1'b0; iFoodEaten = 1'b0; iDrawDone = 1'b0;
        test_reset();
        test_start();
        test_step_timing();
        test_food_levels();
        test_pause();
        test_overrun();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
